dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
Sequencer that drives the DDS frequency control word. It steps the word from a start value to a stop value by a fixed increment, holding each word for a programmed number of clock cycles. Sweeps are single-shot or continuous. It sits upstream of the phase accumulator and the theoretical-frequency display, and feeds both the same control word.

Parameters:
KW, 8, control-word width (must match the DDS accumulator increment width)
DW, 16, dwell-counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  sweep request; sampled only in IDLE
abort  input  1  terminate sweep; highest priority
cfg_start  input  KW  first control word
cfg_stop  input  KW  last permissible control word
cfg_step  input  KW  increment per step
cfg_dwell  input  DW  cycles each word is held (0 treated as 1)
cfg_cont  input  1  1 = restart from cfg_start at end of sweep
cfg_bidir  input  1  up/down sweep select; used only with the optional feature
ctrl  output  KW  frequency control word to the DDS
ctrl_vld  output  1  one-cycle pulse each time a new word is presented
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at normal sweep completion
cfg_err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async, rst_n=0): state IDLE; ctrl=0, ctrl_vld=0, busy=0, done=0, cfg_err=0; internal config and dwell counter are cleared.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1:
  - If cfg_step==0 or cfg_start>cfg_stop: pulse cfg_err next cycle, stay in IDLE, ctrl unchanged.
  - Otherwise: latch all cfg_* inputs, then on the next edge set ctrl=cfg_start, ctrl_vld=1, busy=1, go to RUN.
  - cfg_* changes after the latch have no effect until the next start.
- RUN:
  - Let D = max(latched dwell, 1). Each word is held exactly D cycles, counted from the cycle ctrl_vld is high.
  - At dwell expiry, compute next = ctrl + step in KW+1 bits.
  - If next <= stop (carry bit clear): ctrl=next, ctrl_vld=1.
  - Otherwise the sweep is at its end:
    - cont=1: ctrl=start, ctrl_vld=1, stay in RUN. The pulse occurs even when the value does not change.
    - cont=0: go to FIN.
- FIN: done=1 and busy=0 for one cycle, then IDLE. ctrl holds the last emitted word indefinitely.
- Single-shot timing: for N emitted words with start sampled at edge T, the first ctrl_vld is at T+1 and done is high at T+1+N*D.
- abort=1 in any non-IDLE state: go to IDLE at the next edge with busy=0. ctrl holds, done stays 0, ctrl_vld stays 0. abort takes priority over dwell expiry in the same cycle.
- start while busy: ignored. start in the same cycle as abort: abort wins; start is not re-sampled until IDLE.
- start==stop: exactly one word is emitted, then FIN (or repeats of that word when cont=1).
- Wrap-around: the next word is never emitted when ctrl+step exceeds 2^KW-1. The sweep ends instead; there is no modulo wrap.
- All outputs are registered. ctrl_vld, done and cfg_err are never high for two consecutive cycles from the same event.

Optional Feature:
- Macro DDS_SWEEP_BIDIR_EN.
- When defined and latched cfg_bidir=1:
  - After the last upward word, the sweep descends by step.
  - The turning word is not repeated.
  - Descent stops at the last word >= start, computed with a borrow check.
  - That word ends the pass: FIN, or reload of the upward sweep when cont=1.
- When not defined: cfg_bidir is ignored (port retained, unconnected internally) and no down-count logic is synthesized.

Test Plan:
1. start=10, stop=40, step=10, dwell=3, cont=0 -> ctrl sequence 10,20,30,40, each held 3 cycles; 4 ctrl_vld pulses; done at T+13; busy low from T+13.
2. start=200, stop=255, step=50, dwell=1 -> ctrl 200 then 250; 300 is not emitted; done at T+3; ctrl holds 250.
3. step=0, or start=50 with stop=40 -> cfg_err single pulse; busy stays 0; ctrl keeps its prior value; no ctrl_vld.
4. start=0, stop=2, step=1, dwell=1, cont=1 -> 0,1,2,0,1,... with ctrl_vld every cycle; abort mid-sweep -> busy=0 next edge, ctrl frozen, done never asserted.
5. rst_n low mid-sweep (asynchronous, between edges) -> ctrl=0 and all flags 0 immediately; after release, start runs a fresh sweep correctly.
6. With DDS_SWEEP_BIDIR_EN: start=1, stop=3, step=1, dwell=2, bidir=1 -> 1,2,3,2,1, each held 2 cycles, then done. Without the macro, the same stimulus gives 1,2,3 then done.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS control word from start to stop, holding each word for a dwell period.
// Define DDS_SWEEP_BIDIR_EN to add the descending half of a bidirectional sweep.
module dds_sweep_ctrl #(
    parameter int KW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] cfg_start,
    input  logic [KW-1:0] cfg_stop,
    input  logic [KW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_cont,
    input  logic          cfg_bidir,
    output logic [KW-1:0] ctrl,
    output logic          ctrl_vld,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state;
    logic pend;
    logic [KW-1:0] start_q, stop_q, step_q, nxt;
    logic [DW-1:0] dwell_q, cnt, hold;
    logic cont_q, go;
    logic [KW:0] up_nxt;
`ifdef DDS_SWEEP_BIDIR_EN
    logic bidir_q, down, turn, dn_ok, nxt_down;
    logic [KW:0] dn_nxt;
`else
    logic unused_bidir;
    assign unused_bidir = cfg_bidir;
`endif
    // a dwell of 0 behaves as 1, so the reload value saturates at 0
    assign hold = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
    always_comb begin
        up_nxt = {1'b0, ctrl} + {1'b0, step_q};
`ifdef DDS_SWEEP_BIDIR_EN
        dn_nxt   = {1'b0, ctrl} - {1'b0, step_q};
        dn_ok    = bidir_q && !dn_nxt[KW] && dn_nxt[KW-1:0] >= start_q;
        turn     = down || up_nxt > {1'b0, stop_q};
        go       = turn ? dn_ok : 1'b1;
        nxt      = turn ? dn_nxt[KW-1:0] : up_nxt[KW-1:0];
        nxt_down = turn && dn_ok;
`else
        go  = up_nxt <= {1'b0, stop_q};
        nxt = up_nxt[KW-1:0];
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= 1'b0;
            ctrl     <= '0;
            ctrl_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            cont_q   <= 1'b0;
            cnt      <= '0;
`ifdef DDS_SWEEP_BIDIR_EN
            bidir_q  <= 1'b0;
            down     <= 1'b0;
`endif
        end else begin
            ctrl_vld <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // pend marks the cycle between latching the config and emitting the first word
                    if (abort) pend <= 1'b0;
                    else if (pend) begin
                        pend     <= 1'b0;
                        ctrl     <= start_q;
                        ctrl_vld <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= hold;
                        state    <= RUN;
`ifdef DDS_SWEEP_BIDIR_EN
                        down     <= 1'b0;
`endif
                    end else if (start) begin
                        if (cfg_step == '0 || cfg_start > cfg_stop) cfg_err <= 1'b1;
                        else begin
                            pend    <= 1'b1;
                            start_q <= cfg_start;
                            stop_q  <= cfg_stop;
                            step_q  <= cfg_step;
                            dwell_q <= cfg_dwell;
                            cont_q  <= cfg_cont;
`ifdef DDS_SWEEP_BIDIR_EN
                            bidir_q <= cfg_bidir;
`endif
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (go) begin
                        ctrl     <= nxt;
                        ctrl_vld <= 1'b1;
                        cnt      <= hold;
`ifdef DDS_SWEEP_BIDIR_EN
                        down     <= nxt_down;
`endif
                    end else if (cont_q) begin
                        ctrl     <= start_q;
                        ctrl_vld <= 1'b1;
                        cnt      <= hold;
`ifdef DDS_SWEEP_BIDIR_EN
                        down     <= 1'b0;
`endif
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: randomized and directed checks of dds_sweep_ctrl against a word-list model.
// Honours DDS_SWEEP_BIDIR_EN the same way the design does.
module tb_dds_sweep_ctrl;
    localparam int KW = 8;
    localparam int DW = 16;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, cfg_cont = 1'b0, cfg_bidir = 1'b0;
    logic [KW-1:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic [KW-1:0] ctrl;
    logic ctrl_vld, busy, done, cfg_err;
    int total = 0, bad = 0;
    int words[$];
    logic [KW-1:0] last_ctrl = '0;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.KW(KW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
        .cfg_cont(cfg_cont), .cfg_bidir(cfg_bidir),
        .ctrl(ctrl), .ctrl_vld(ctrl_vld), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    // one pass of the sweep as a list of words
    function automatic void build_words(input int s, input int e, input int st, input bit bd);
        int w = s;
        words.delete();
        words.push_back(w);
        while (w + st <= e && w + st <= 255) begin
            w += st;
            words.push_back(w);
        end
`ifdef DDS_SWEEP_BIDIR_EN
        if (bd) while (w - st >= s) begin
            w -= st;
            words.push_back(w);
        end
`else
        if (bd) w = w;
`endif
    endfunction

    task automatic test_reset();
        logic [KW+3:0] got;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            got = {ctrl, ctrl_vld, busy, done, cfg_err};
            total++;
            if (got !== '0) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h exp=0", k, got);
            end
        end
        rst_n = 1'b1;
        last_ctrl = '0;
    endtask

    task automatic test_sweep(input string name, input int s, input int e, input int st, input int dw,
                              input bit bd, input bit poke);
        int d = (dw == 0) ? 1 : dw;
        int n;
        logic [KW+3:0] got, exp;
        build_words(s, e, st, bd);
        n = words.size();
        @(negedge clk);
        cfg_start = KW'(s); cfg_stop = KW'(e); cfg_step = KW'(st); cfg_dwell = DW'(dw);
        cfg_cont = 1'b0; cfg_bidir = bd; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cfg_start = KW'($urandom); cfg_stop = KW'($urandom); cfg_step = KW'($urandom);
        cfg_dwell = DW'($urandom_range(0, 5)); cfg_cont = 1'($urandom); cfg_bidir = 1'($urandom);
        got = {ctrl, ctrl_vld, busy, done, cfg_err};
        exp = {last_ctrl, 4'b0000};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s latch got=%h exp=%h", name, got, exp);
        end
        for (int k = 0; k < n * d; k++) begin
            @(negedge clk);
            got = {ctrl, ctrl_vld, busy, done, cfg_err};
            exp = {KW'(words[k / d]), (k % d) == 0, 1'b1, 1'b0, 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, got, exp);
            end
            start = poke && k == 1;
        end
        last_ctrl = KW'(words[n - 1]);
        @(negedge clk);
        start = 1'b0;
        got = {ctrl, ctrl_vld, busy, done, cfg_err};
        exp = {last_ctrl, 4'b0010};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s done got=%h exp=%h", name, got, exp);
        end
        @(negedge clk);
        got = {ctrl, ctrl_vld, busy, done, cfg_err};
        exp = {last_ctrl, 4'b0000};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s after got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_cfg_err(input string name, input int s, input int e, input int st);
        logic [KW+3:0] got, exp;
        @(negedge clk);
        cfg_start = KW'(s); cfg_stop = KW'(e); cfg_step = KW'(st); cfg_dwell = 1; cfg_cont = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got = {ctrl, ctrl_vld, busy, done, cfg_err};
            exp = {last_ctrl, 3'b000, k == 0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cont_abort(input string name, input int s, input int e, input int st, input int dw,
                                   input bit bd, input int ncyc);
        int d = (dw == 0) ? 1 : dw;
        int n;
        logic [KW-1:0] frozen;
        logic [KW+3:0] got, exp;
        build_words(s, e, st, bd);
        n = words.size();
        @(negedge clk);
        cfg_start = KW'(s); cfg_stop = KW'(e); cfg_step = KW'(st); cfg_dwell = DW'(dw);
        cfg_cont = 1'b1; cfg_bidir = bd; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            got = {ctrl, ctrl_vld, busy, done, cfg_err};
            exp = {KW'(words[(k / d) % n]), (k % d) == 0, 1'b1, 1'b0, 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, got, exp);
            end
        end
        frozen = KW'(words[((ncyc - 1) / d) % n]);
        abort = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            abort = 1'b0;
            got = {ctrl, ctrl_vld, busy, done, cfg_err};
            exp = {frozen, 4'b0000};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s abort cyc=%0d got=%h exp=%h", name, j, got, exp);
            end
        end
        last_ctrl = frozen;
        cfg_cont = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [KW+3:0] got;
        @(negedge clk);
        cfg_start = 8'd10; cfg_stop = 8'd200; cfg_step = 8'd10; cfg_dwell = 2; cfg_cont = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 got = {ctrl, ctrl_vld, busy, done, cfg_err};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL async_reset immediate got=%h exp=0", got);
        end
        @(negedge clk);
        got = {ctrl, ctrl_vld, busy, done, cfg_err};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL async_reset held got=%h exp=0", got);
        end
        rst_n = 1'b1;
        last_ctrl = '0;
    endtask

    initial begin
        int s;
        test_reset();
        test_sweep("plan1", 10, 40, 10, 3, 1'b0, 1'b1);
        test_sweep("plan2", 200, 255, 50, 1, 1'b0, 1'b0);
        test_cfg_err("step0", 10, 40, 0);
        test_cfg_err("order", 50, 40, 10);
        test_sweep("single", 77, 77, 5, 2, 1'b0, 1'b0);
        test_sweep("edge255", 245, 255, 10, 0, 1'b0, 1'b0);
        test_sweep("nowrap", 250, 255, 10, 1, 1'b0, 1'b0);
        test_cont_abort("plan4", 0, 2, 1, 1, 1'b0, 7);
        test_async_reset();
        test_sweep("post_reset", 5, 20, 5, 2, 1'b0, 1'b0);
        test_sweep("bidir", 1, 3, 1, 2, 1'b1, 1'b0);
        test_sweep("bidir_wide", 0, 250, 100, 1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            s = int'($urandom_range(0, 200));
            test_sweep("rand", s, s + int'($urandom_range(0, 55)), int'($urandom_range(1, 40)),
                       int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 4; i++) begin
            s = int'($urandom_range(0, 200));
            test_cont_abort("rand_cont", s, s + int'($urandom_range(0, 30)), int'($urandom_range(1, 20)),
                            int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(3, 25)));
        end
        for (int i = 0; i < 3; i++) begin
            s = int'($urandom_range(1, 255));
            test_cfg_err("rand_err", s, int'($urandom_range(0, s - 1)), int'($urandom_range(1, 255)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
